alu_seq: RTL

Parametrised sequential ALU for the SAP-style datapath. It succeeds the 8-bit combinational ALU.
- Operands are captured on a start handshake.
- Single-cycle logic/arithmetic runs alongside multi-cycle barrel-free shifts and shift-add multiply.
- Result and a Z/N/C/V flag register are held until the next operation.
- The result drives the shared bus through a tri-state output controlled by alu_out, as before.

---
 rtl/alu_pkg.sv | 53 +++++
 rtl/alu_core.sv | 81 ++++++++
 rtl/alu_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequential ALU:
//   - opcode values OP_ADD .. OP_CMP (0xD-0xF are reserved)
//   - FSM state encoding IDLE / SHIFT / MUL
//   - flag bit positions inside the 4-bit {V,C,N,Z} flag vector
//   - small helpers used by both the core and the top level
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;
  localparam logic [3:0] OP_AND = 4'h2;
  localparam logic [3:0] OP_OR  = 4'h3;
  localparam logic [3:0] OP_XOR = 4'h4;
  localparam logic [3:0] OP_NOT = 4'h5;
  localparam logic [3:0] OP_ADC = 4'h6;
  localparam logic [3:0] OP_SBB = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_SAR = 4'hA;
  localparam logic [3:0] OP_MUL = 4'hB;
  localparam logic [3:0] OP_CMP = 4'hC;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    MUL   = 2'd2
  } state_t;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;
  localparam int FLG_V = 3;

  // True for the three opcodes that iterate through the SHIFT state.
  function automatic logic is_shift_op(input logic [3:0] op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_SAR);
  endfunction

  // Packs individual flag bits into the flag vector using the indices above.
  function automatic logic [3:0] make_flags(input logic z, input logic n,
                                            input logic c, input logic v);
    logic [3:0] f;
    f        = '0;
    f[FLG_Z] = z;
    f[FLG_N] = n;
    f[FLG_C] = c;
    f[FLG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_core.sv
// ---------------------------------------------------------------------------
// alu_core
// Purely combinational evaluation of the single-cycle opcodes
// (ADD, SUB, AND, OR, XOR, NOT, ADC, SBB, CMP).
// Ports:
//   op          opcode being started
//   a, b        operands
//   cin         carry / borrow input for ADC / SBB
//   cur_result  currently held result (kept for CMP and non-core opcodes)
//   cur_flags   currently held flags (kept for non-core opcodes)
//   nxt_result  result to load at commit
//   nxt_flags   {V,C,N,Z} to load at commit
// ---------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] cur_result,
  input  logic [3:0]       cur_flags,
  output logic [WIDTH-1:0] nxt_result,
  output logic [3:0]       nxt_flags
);

  localparam int MSB = WIDTH - 1;

  logic             cin_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] val;
  logic             c_bit;
  logic             v_bit;
  logic             upd_res;
  logic             upd_flags;

  // The adder and subtractor are one bit wider than the datapath so that the
  // top bit is the carry out / borrow out. Only ADC and SBB consume carry_in.
  // CMP evaluates the difference for its flags but leaves the result alone;
  // opcodes not handled here pass the held result and flags straight through.
  always_comb begin
    cin_eff   = (op == OP_ADC) || (op == OP_SBB) ? cin : 1'b0;
    sum       = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin_eff};
    diff      = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin_eff};
    val       = '0;
    c_bit     = 1'b0;
    v_bit     = 1'b0;
    upd_res   = 1'b1;
    upd_flags = 1'b1;

    case (op)
      OP_ADD, OP_ADC: begin
        val   = sum[WIDTH-1:0];
        c_bit = sum[WIDTH];
        v_bit = (a[MSB] == b[MSB]) && (val[MSB] != a[MSB]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        val     = diff[WIDTH-1:0];
        c_bit   = diff[WIDTH];
        v_bit   = (a[MSB] != b[MSB]) && (val[MSB] != a[MSB]);
        upd_res = (op != OP_CMP);
      end
      OP_AND: val = a & b;
      OP_OR:  val = a | b;
      OP_XOR: val = a ^ b;
      OP_NOT: val = ~a;
      default: begin
        upd_res   = 1'b0;
        upd_flags = 1'b0;
      end
    endcase

    nxt_result = upd_res ? val : cur_result;
    nxt_flags  = upd_flags ? make_flags((val == '0), val[MSB], c_bit, v_bit)
                           : cur_flags;
  end

endmodule

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Sequential ALU: single-cycle logic/arithmetic, bit-serial shifts and a
// shift-add multiplier, with a held result and {V,C,N,Z} flag register that
// can be driven onto the shared bus.
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   start     operation request, only honoured while idle
//   op        opcode (captured with start)
//   carry_in  carry / borrow for ADC / SBB (captured with start)
//   a_in      accumulator operand (captured with start)
//   b_in      B-register operand; b_in[SHW-1:0] is the shift amount
//   alu_out   bus enable for bus_out
//   busy      shift or multiply in progress
//   done      one-cycle completion pulse
//   flags     registered {V,C,N,Z}
//   result    registered result
//   bus_out   result when alu_out=1, high impedance otherwise
// ---------------------------------------------------------------------------
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic             carry_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             alu_out,
  output logic             busy,
  output logic             done,
  output logic [3:0]       flags,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] bus_out
);

  // The counter must be able to hold WIDTH itself (multiply iteration count).
  localparam int             CW      = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH);

  state_t               state_q,  state_d;
  logic [CW-1:0]        cnt_q,    cnt_d;
  logic [3:0]           op_q,     op_d;
  logic [WIDTH-1:0]     sh_q,     sh_d;
  logic [2*WIDTH-1:0]   acc_q,    acc_d;
  logic [2*WIDTH-1:0]   mcand_q,  mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [3:0]           flags_q,  flags_d;
  logic                 done_q,   done_d;

  logic [WIDTH-1:0]     core_result;
  logic [3:0]           core_flags;
  logic [CW-1:0]        s_amt;
  logic                 last_step;
  logic [WIDTH-1:0]     sh_next;
  logic                 sh_out;
  logic [2*WIDTH-1:0]   acc_sum;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .op         (op),
    .a          (a_in),
    .b          (b_in),
    .cin        (carry_in),
    .cur_result (result_q),
    .cur_flags  (flags_q),
    .nxt_result (core_result),
    .nxt_flags  (core_flags)
  );

  // Shift amount from the low bits of b_in. For non-power-of-two widths the
  // field can encode values above WIDTH, so it is clamped.
  always_comb begin
    s_amt = CW'(b_in[SHW-1:0]);
    if (s_amt > CNT_MAX) begin
      s_amt = CNT_MAX;
    end
  end

  // One step of the iterative units. The shifter moves one bit per cycle and
  // remembers the bit that fell off; the multiplier adds the shifted
  // multiplicand whenever the current multiplier LSB is set. The final
  // iteration is the one that starts with the counter at 1.
  always_comb begin
    last_step = (cnt_q == CW'(1));
    case (op_q)
      OP_SHL: begin
        sh_out  = sh_q[WIDTH-1];
        sh_next = {sh_q[WIDTH-2:0], 1'b0};
      end
      OP_SAR: begin
        sh_out  = sh_q[0];
        sh_next = {sh_q[WIDTH-1], sh_q[WIDTH-1:1]};
      end
      default: begin
        sh_out  = sh_q[0];
        sh_next = {1'b0, sh_q[WIDTH-1:1]};
      end
    endcase
    acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // State register plus every datapath flop. Reset clears everything, which
  // also drops any operation in flight without a completion pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      sh_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      result_q <= '0;
      flags_q  <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      sh_q     <= sh_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      done_q   <= done_d;
    end
  end

  // Next-state logic. A zero-length shift never leaves IDLE; every iterative
  // operation returns to IDLE on the step that commits.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_shift_op(op) && (s_amt != '0)) begin
            state_d = SHIFT;
          end else if (op == OP_MUL) begin
            state_d = MUL;
          end
        end
      end
      SHIFT, MUL: begin
        if (last_step) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output logic. Flags are written only when an operation
  // commits; the multiplier's carry/overflow report any bits lost in the
  // upper half of the double-width product.
  always_comb begin
    cnt_d    = cnt_q;
    op_d     = op_q;
    sh_d     = sh_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    result_d = result_q;
    flags_d  = flags_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          op_d = op;
          if (is_shift_op(op)) begin
            if (s_amt == '0) begin
              result_d = a_in;
              flags_d  = make_flags((a_in == '0), a_in[WIDTH-1], 1'b0, 1'b0);
              done_d   = 1'b1;
            end else begin
              cnt_d = s_amt;
              sh_d  = a_in;
            end
          end else if (op == OP_MUL) begin
            cnt_d    = CNT_MAX;
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a_in};
            mplier_d = b_in;
          end else begin
            result_d = core_result;
            flags_d  = core_flags;
            done_d   = 1'b1;
          end
        end
      end
      SHIFT: begin
        sh_d  = sh_next;
        cnt_d = cnt_q - CW'(1);
        if (last_step) begin
          result_d = sh_next;
          flags_d  = make_flags((sh_next == '0), sh_next[WIDTH-1], sh_out, 1'b0);
          done_d   = 1'b1;
        end
      end
      MUL: begin
        acc_d    = acc_sum;
        mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
        cnt_d    = cnt_q - CW'(1);
        if (last_step) begin
          result_d = acc_sum[WIDTH-1:0];
          flags_d  = make_flags((acc_sum[WIDTH-1:0] == '0), acc_sum[WIDTH-1],
                                (acc_sum[2*WIDTH-1:WIDTH] != '0),
                                (acc_sum[2*WIDTH-1:WIDTH] != '0));
          done_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign flags   = flags_q;
  assign result  = result_q;
  assign bus_out = alu_out ? result_q : {WIDTH{1'bz}};

endmodule
